// File: rtl/sipo_framer.sv
// Lane-serial to word-parallel framer with per-frame lane order, output holding register
// and flush-with-pad for partial frames.
module sipo_framer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANE_WIDTH = 1,
  localparam int unsigned BEATS = DATA_WIDTH / LANE_WIDTH,
  localparam int unsigned CW = $clog2(BEATS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [LANE_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  msb_first,
  input  logic                  flush,
  input  logic                  pad_ones,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CW-1:0]         out_lanes,
  output logic                  busy
);

  localparam logic [CW-1:0] LastCount = CW'(BEATS - 1);
  localparam logic [CW-1:0] FullCount = CW'(BEATS);

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         out_lanes_q, out_lanes_d;
  logic                  order_q, order_d;
  logic                  flush_pending_q, flush_pending_d;
  logic                  out_valid_q, out_valid_d;

  logic                  slot_free, beat_acc, beat_msb, frame_done, flush_done;
  logic [DATA_WIDTH-1:0] shifted, flush_word, pad_word, lane_mask;
  int unsigned           shamt;

  always_comb begin
    slot_free  = !out_valid_q || out_ready;
    in_ready   = !flush_pending_q && !(count_q == LastCount && !slot_free);
    beat_acc   = in_valid && in_ready;
    // The first beat of a frame uses the live order input; later beats use the latch.
    beat_msb   = (count_q == '0) ? msb_first : order_q;
    frame_done = beat_acc && (count_q == LastCount);
    flush_done = flush_pending_q && slot_free;

    if (beat_msb) shifted = {shift_q[DATA_WIDTH-LANE_WIDTH-1:0], in_data};
    else          shifted = {in_data, shift_q[DATA_WIDTH-1:LANE_WIDTH]};

    // Captured lanes sit at the entry end of the shifter; move them to the frame's first lane.
    shamt    = (BEATS - 32'(count_q)) * LANE_WIDTH;
    pad_word = {DATA_WIDTH{pad_ones}};
    if (order_q) begin
      lane_mask  = {DATA_WIDTH{1'b1}} << shamt;
      flush_word = (shift_q << shamt) | (pad_word & ~lane_mask);
    end else begin
      lane_mask  = {DATA_WIDTH{1'b1}} >> shamt;
      flush_word = (shift_q >> shamt) | (pad_word & ~lane_mask);
    end
  end

  always_comb begin
    shift_d         = shift_q;
    data_out_d      = data_out_q;
    count_d         = count_q;
    out_lanes_d     = out_lanes_q;
    order_d         = order_q;
    flush_pending_d = flush_pending_q;
    out_valid_d     = out_valid_q;

    if (beat_acc) begin
      shift_d = shifted;
      if (count_q == '0) order_d = msb_first;
    end

    if (frame_done) begin
      // A flush arriving with the completing beat is absorbed by the full frame.
      data_out_d  = shifted;
      out_valid_d = 1'b1;
      out_lanes_d = FullCount;
      count_d     = '0;
    end else if (flush_done) begin
      data_out_d      = flush_word;
      out_valid_d     = 1'b1;
      out_lanes_d     = count_q;
      count_d         = '0;
      flush_pending_d = 1'b0;
    end else begin
      if (beat_acc) count_d = count_q + 1'b1;
      if (flush && (beat_acc || count_q != '0)) flush_pending_d = 1'b1;
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q         <= '0;
      data_out_q      <= '0;
      count_q         <= '0;
      out_lanes_q     <= '0;
      order_q         <= 1'b0;
      flush_pending_q <= 1'b0;
      out_valid_q     <= 1'b0;
    end else begin
      shift_q         <= shift_d;
      data_out_q      <= data_out_d;
      count_q         <= count_d;
      out_lanes_q     <= out_lanes_d;
      order_q         <= order_d;
      flush_pending_q <= flush_pending_d;
      out_valid_q     <= out_valid_d;
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign out_lanes = out_lanes_q;
  assign busy      = (count_q != '0) || flush_pending_q;

endmodule

// File: tb/tb_sipo_framer.sv
// Bench for sipo_framer: an 8/1 and a 16/4 instance checked each cycle against a lane-list
// reference model, with directed scenarios followed by random traffic.
module tb_sipo_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic       in_data_a, in_valid_a, in_ready_a, msb_a, flush_a, pad_a, out_ready_a;
  logic       out_valid_a, busy_a;
  logic [7:0] data_out_a;
  logic [3:0] out_lanes_a;

  logic [3:0]  in_data_b;
  logic        in_valid_b, in_ready_b, msb_b, flush_b, pad_b, out_ready_b, out_valid_b, busy_b;
  logic [15:0] data_out_b;
  logic [2:0]  out_lanes_b;

  sipo_framer #(.DATA_WIDTH(8), .LANE_WIDTH(1)) u_dut_a (
    .clk(clk), .reset(reset), .in_data(in_data_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .msb_first(msb_a), .flush(flush_a), .pad_ones(pad_a),
    .data_out(data_out_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_lanes(out_lanes_a), .busy(busy_a)
  );

  sipo_framer #(.DATA_WIDTH(16), .LANE_WIDTH(4)) u_dut_b (
    .clk(clk), .reset(reset), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .msb_first(msb_b), .flush(flush_b), .pad_ones(pad_b),
    .data_out(data_out_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_lanes(out_lanes_b), .busy(busy_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a list of received lanes per instance plus the holding register.
  int          m_cnt  [2];
  int          m_lane [2][16];
  bit          m_msb  [2];
  bit          m_fp   [2];
  bit          m_ov   [2];
  int          m_ol   [2];
  logic [15:0] m_word [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int beats_of(input int k);
    return (k == 0) ? 8 : 4;
  endfunction

  function automatic int lw_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  // Lane i (arrival order) goes to position i (LSB-first) or BEATS-1-i (MSB-first).
  function automatic logic [15:0] build(input int k, input int n, input bit pad);
    logic [15:0] w, mask, val;
    int          pos;
    w    = '0;
    mask = (16'd1 << lw_of(k)) - 16'd1;
    for (int i = 0; i < beats_of(k); i++) begin
      val = (i < n) ? 16'(m_lane[k][i]) : (pad ? mask : 16'd0);
      pos = m_msb[k] ? (beats_of(k) - 1 - i) : i;
      w   = w | ((val & mask) << (pos * lw_of(k)));
    end
    return w;
  endfunction

  function automatic bit model_rdy(input int k, input bit ordy);
    return !m_fp[k] && !(m_cnt[k] == beats_of(k) - 1 && !(!m_ov[k] || ordy));
  endfunction

  task automatic model_step(input int k, input bit v, input int d, input bit msb, input bit fl,
                            input bit pad, input bit ordy, input bit rst);
    bit slot, acc, pend, emitted;
    if (rst) begin
      m_cnt[k] = 0; m_fp[k] = 0; m_ov[k] = 0; m_ol[k] = 0; m_word[k] = '0; m_msb[k] = 0;
      return;
    end
    slot    = !m_ov[k] || ordy;
    acc     = v && model_rdy(k, ordy);
    pend    = m_fp[k];
    emitted = 0;
    if (pend && slot) begin
      m_word[k] = build(k, m_cnt[k], pad);
      m_ol[k]   = m_cnt[k];
      m_cnt[k]  = 0;
      m_fp[k]   = 0;
      emitted   = 1;
    end else if (acc) begin
      if (m_cnt[k] == 0) m_msb[k] = msb;
      m_lane[k][m_cnt[k]] = d;
      m_cnt[k]++;
      if (m_cnt[k] == beats_of(k)) begin
        m_word[k] = build(k, beats_of(k), 1'b0);
        m_ol[k]   = beats_of(k);
        m_cnt[k]  = 0;
        emitted   = 1;
      end
    end
    if (!pend && !emitted && fl && m_cnt[k] != 0) m_fp[k] = 1;
    if (emitted) m_ov[k] = 1;
    else if (m_ov[k] && ordy) m_ov[k] = 0;
  endtask

  task automatic check_outputs();
    check("out_valid_a", out_valid_a, m_ov[0]);
    check("data_out_a", data_out_a, m_word[0][7:0]);
    check("out_lanes_a", out_lanes_a, m_ol[0]);
    check("busy_a", busy_a, (m_cnt[0] != 0) || m_fp[0]);
    check("out_valid_b", out_valid_b, m_ov[1]);
    check("data_out_b", data_out_b, m_word[1]);
    check("out_lanes_b", out_lanes_b, m_ol[1]);
    check("busy_b", busy_b, (m_cnt[1] != 0) || m_fp[1]);
  endtask

  // Inputs are set at the falling edge; this advances one rising edge and checks.
  task automatic tick();
    #1;
    check("in_ready_a", in_ready_a, model_rdy(0, out_ready_a));
    check("in_ready_b", in_ready_b, model_rdy(1, out_ready_b));
    model_step(0, in_valid_a, int'(in_data_a), msb_a, flush_a, pad_a, out_ready_a, reset);
    model_step(1, in_valid_b, int'(in_data_b), msb_b, flush_b, pad_b, out_ready_b, reset);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_idle();
    in_valid_a = 0; in_data_a = 0; msb_a = 0; flush_a = 0; pad_a = 0; out_ready_a = 1;
    in_valid_b = 0; in_data_b = 0; msb_b = 0; flush_b = 0; pad_b = 0; out_ready_b = 1;
  endtask

  task automatic feed_a(input logic [7:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid_a = 1;
      in_data_a  = bits[i];
      tick();
    end
    in_valid_a = 0;
  endtask

  logic [15:0] nib;

  initial begin
    set_idle();
    reset = 1;
    model_step(0, 0, 0, 0, 0, 0, 1, 1);
    model_step(1, 0, 0, 0, 0, 0, 1, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    check_outputs();
    check("rst_valid", out_valid_a, 0);
    check("rst_busy", busy_a, 0);

    // Plain LSB-first frame, one-cycle valid pulse.
    feed_a(8'h4D, 8);
    check("t1_word", data_out_a, 8'h4D);
    check("t1_lanes", out_lanes_a, 8);
    check("t1_valid", out_valid_a, 1);
    tick();
    check("t1_pulse", out_valid_a, 0);

    // MSB-first, then order toggled mid-frame, then next frame with new order.
    msb_a = 1;
    feed_a(8'h4D, 8);
    check("t2_msb", data_out_a, 8'hB2);
    for (int i = 0; i < 8; i++) begin
      msb_a = (i < 3);
      in_valid_a = 1;
      in_data_a = nib[0];
      nib = 16'h4D >> i;
      in_data_a = nib[0];
      tick();
    end
    in_valid_a = 0;
    check("t2_toggle", data_out_a, 8'hB2);
    feed_a(8'h4D, 8);
    check("t2_next", data_out_a, 8'h4D);

    // 16/4 instance: two back-to-back frames, no bubbles.
    nib = 16'hDCBA;
    for (int i = 0; i < 8; i++) begin
      msb_b = (i >= 4);
      in_valid_b = 1;
      in_data_b = 4'(nib >> (4 * (i % 4)));
      #1;
      check("t3_ready", in_ready_b, 1);
      tick();
      if (i == 3) check("t3_lsb", data_out_b, 16'hDCBA);
    end
    in_valid_b = 0;
    msb_b = 0;
    check("t3_msb", data_out_b, 16'hABCD);
    check("t3_lanes", out_lanes_b, 4);

    // Backpressure: second frame's last beat waits for the drain edge.
    tick();
    out_ready_a = 0;
    feed_a(8'h4D, 8);
    check("t4_hold", out_valid_a, 1);
    feed_a(8'hA5, 7);
    in_valid_a = 1;
    in_data_a = 1'b1;
    #1;
    check("t4_refuse", in_ready_a, 0);
    tick();
    check("t4_kept", data_out_a, 8'h4D);
    out_ready_a = 1;
    tick();
    in_valid_a = 0;
    check("t4_frame2", data_out_a, 8'hA5);
    check("t4_valid2", out_valid_a, 1);
    tick();

    // Flush variants.
    feed_a(8'b011, 3);
    flush_a = 1;
    tick();
    flush_a = 0;
    tick();
    check("t5_pad0", data_out_a, 8'h03);
    check("t5_lanes", out_lanes_a, 3);
    feed_a(8'b011, 3);
    flush_a = 1;
    tick();
    flush_a = 0;
    pad_a = 1;
    tick();
    pad_a = 0;
    check("t5_pad1", data_out_a, 8'hFB);
    msb_a = 1;
    feed_a(8'b011, 3);
    msb_a = 0;
    flush_a = 1;
    tick();
    flush_a = 0;
    tick();
    check("t5_msb", data_out_a, 8'hC0);
    tick();
    flush_a = 1;
    tick();
    flush_a = 0;
    tick();
    check("t5_empty", out_valid_a, 0);
    check("t5_idle", busy_a, 0);
    feed_a(8'h4D, 7);
    in_valid_a = 1;
    in_data_a = 1'b0;
    flush_a = 1;
    tick();
    in_valid_a = 0;
    flush_a = 0;
    check("t5_full", out_lanes_a, 8);
    check("t5_fword", data_out_a, 8'h4D);
    tick();
    check("t5_nopend", out_valid_a, 0);

    // Reset mid-frame with a word held.
    out_ready_a = 0;
    feed_a(8'h4D, 8);
    feed_a(8'hFF, 5);
    reset = 1;
    tick();
    reset = 0;
    check("t6_valid", out_valid_a, 0);
    check("t6_data", data_out_a, 0);
    check("t6_busy", busy_a, 0);
    out_ready_a = 1;
    feed_a(8'h96, 8);
    check("t6_clean", data_out_a, 8'h96);

    // Random traffic on both instances.
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 299) == 0);
      in_valid_a  = ($urandom_range(0, 9) < 7);
      in_data_a   = 1'($urandom_range(0, 1));
      msb_a       = 1'($urandom_range(0, 1));
      flush_a     = ($urandom_range(0, 19) == 0);
      pad_a       = 1'($urandom_range(0, 1));
      out_ready_a = ($urandom_range(0, 9) < 6);
      in_valid_b  = ($urandom_range(0, 9) < 7);
      in_data_b   = 4'($urandom_range(0, 15));
      msb_b       = 1'($urandom_range(0, 1));
      flush_b     = ($urandom_range(0, 19) == 0);
      pad_b       = 1'($urandom_range(0, 1));
      out_ready_b = ($urandom_range(0, 9) < 6);
      tick();
    end
    reset = 0;
    set_idle();
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_framer.md
Name: sipo_framer

Overview:
Parametrised successor to the team's bit-serial SIPO shifter. It assembles LANE_WIDTH-bit beats into DATA_WIDTH-bit words with a selectable first-lane order. Input and output both use valid/ready handshakes, so a completed word can wait in an output holding register while the next frame is assembled. A flush request closes a partial frame, pads it, and reports how many lanes are valid. It sits between serial receive front-ends and word-wide consumers.

Parameters:
DATA_WIDTH, 8, output word width in bits; must be a multiple of LANE_WIDTH.
LANE_WIDTH, 1, bits accepted per input beat.
BEATS, DATA_WIDTH/LANE_WIDTH (derived localparam, not overridable), lanes per word; must be >= 2.
CW, $clog2(BEATS+1) (derived localparam), width of out_lanes.

Ports:
clk  input  1  single clock; all logic on rising edge.
reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
in_data  input  LANE_WIDTH  beat payload.
in_valid  input  1  beat present.
in_ready  output  1  beat can be accepted this cycle.
msb_first  input  1  0: first lane lands at lowest lane; 1: first lane lands at highest lane. Sampled per frame.
flush  input  1  request to close the current partial frame.
pad_ones  input  1  pad value for unfilled lanes on flush (0 = zeros, 1 = ones).
data_out  output  DATA_WIDTH  assembled word (holding register).
out_valid  output  1  data_out is valid.
out_ready  input  1  consumer accepts data_out.
out_lanes  output  CW  number of valid lanes in data_out (BEATS for a full frame).
busy  output  1  frame in assembly (count > 0) or flush pending.

Behaviour:
- Reset, synchronous and active-high, clears the following: shift register, count, frame order latch, flush_pending, data_out=0, out_valid=0, out_lanes=0. Reset mid-frame or mid-hold discards all data. Reset overrides every other input in that cycle.
- Beat accepted when in_valid && in_ready. Output accepted when out_valid && out_ready.
- Output slot is free when !out_valid || out_ready (same-cycle drain counts as free).
- in_ready = !flush_pending && !(count == BEATS-1 && !slot_free). A beat is refused only when it would complete a frame that has nowhere to go.
- Frame order: msb_first is latched on the first accepted beat of a frame (count == 0). Changes mid-frame are ignored until the next frame.
- LSB-first shifting: the shift register shifts right by LANE_WIDTH and the new beat enters the top lane. After BEATS beats, the first beat occupies bits [LANE_WIDTH-1:0].
- MSB-first shifting: the shift register shifts left and the new beat enters the bottom lane. After BEATS beats, the first beat occupies the top lane.
- Completion: the beat that brings count to BEATS transfers the word to data_out on the same edge. Then out_valid=1, out_lanes=BEATS, count=0. Latency is 1 cycle from the final beat to out_valid.
- Full throughput: one word every BEATS cycles when out_ready is held high. There are no bubbles.
- Output accepted with no new completion: out_valid goes to 0 on the next edge. data_out holds its value; it is not cleared.
- Flush behaviour:
  - A flush pulse with count == 0 and no beat accepted that cycle is ignored.
  - Otherwise flush sets flush_pending. A beat accepted in the same cycle is included first.
  - If that beat completes the frame, the flush is consumed and the frame is emitted as a normal full frame.
- Flush completion: when flush_pending && slot_free, data_out takes the n captured lanes, with n = count.
  - LSB-first: the captured lanes occupy the low n lanes in arrival order, and the upper lanes are filled with pad.
  - MSB-first: the captured lanes occupy the top n lanes, and the lower lanes are filled with pad.
  - Pad = all pad_ones, sampled at the completion edge.
  - The same edge sets out_valid=1, out_lanes=n, count=0 and flush_pending=0.
- While flush_pending is set, in_ready=0.
- busy = (count != 0) || flush_pending.

Test Plan:
1. DATA_WIDTH=8, LANE_WIDTH=1, msb_first=0, out_ready=1. Feed bits 1,0,1,1,0,0,1,0 on consecutive cycles -> data_out=0x4D, out_lanes=8, out_valid high for 1 cycle, one cycle after the 8th beat.
2. Same bits with msb_first=1 -> 0xB2. Toggle msb_first after beat 3 -> still 0xB2. The next frame uses the new value.
3. DATA_WIDTH=16, LANE_WIDTH=4, nibbles A,B,C,D back-to-back, two frames with out_ready=1. msb_first=0 -> 0xDCBA; msb_first=1 -> 0xABCD. in_ready stays 1 throughout, so there are no bubbles.
4. Backpressure, 8/1 config, out_ready=0: complete frame 1 -> out_valid=1. The next 7 beats are accepted; the 8th sees in_ready=0. Raise out_ready for 1 cycle -> frame 1 is drained, the 8th beat is accepted on that edge, and frame 2 appears the next cycle with no data loss.
5. Flush, 8/1 config, LSB-first: bits 1,1,0 then flush with pad_ones=0 -> 0x03, out_lanes=3. With pad_ones=1 -> 0xFB. MSB-first with pad_ones=0 -> 0xC0. Flush at count==0 -> no output. Flush together with the 8th beat -> normal full frame, out_lanes=8.
6. Reset asserted after 5 beats with out_valid=1 -> next edge shows out_valid=0, data_out=0, busy=0. The next 8 beats form a clean frame.
